mas_seq_acc: RTL and testbench



---
 rtl/mas_seq_acc_pkg.sv | 26 ++
 rtl/mas_seq_acc_mod_step.sv | 41 ++++
 rtl/mas_seq_acc.sv | 116 +++++++++++
 tb/tb_mas_seq_acc.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mas_seq_acc_pkg.sv
// Shared definitions for the sequential modular accumulator and its mod_step datapath.
package mas_seq_acc_pkg;

  // Operand and modulus width (signed two's complement)
  localparam int unsigned DATA_W = 5;
  localparam int unsigned OP_W   = 2;

  // Opcode encoding, shared with the downstream add/sub stage
  localparam logic [OP_W-1:0] OP_ADD  = 2'b00;
  localparam logic [OP_W-1:0] OP_SUB  = 2'b11;
  localparam logic [OP_W-1:0] OP_LOAD = 2'b01;
  localparam logic [OP_W-1:0] OP_HOLD = 2'b10;

  // Run-control FSM encoding
  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_e;

  // A modulus of zero or below cannot drive a meaningful reduction
  function automatic logic is_bad_mod(input logic [DATA_W-1:0] q);
    return (q == '0) || q[DATA_W-1];
  endfunction

endpackage

// File: rtl/mas_seq_acc_mod_step.sv
// Combinational modular step: 5-bit ALU op followed by a single-correction reduction into [0,q).
module mod_step
  import mas_seq_acc_pkg::*;
(
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] d,
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] q,
  input  logic              bypass,
  output logic [DATA_W-1:0] acc_next
);

  logic signed [DATA_W-1:0] t;
  logic signed [DATA_W-1:0] qs;

  assign qs = $signed(q);

  // Step 1: wrapping ALU operation
  always_comb begin
    t = $signed(acc);
    unique case (op)
      OP_ADD:  t = $signed(acc) + $signed(d);
      OP_SUB:  t = $signed(acc) - $signed(d);
      OP_LOAD: t = $signed(d);
      OP_HOLD: t = $signed(acc);
    endcase
  end

  // Step 2: one correction only; out-of-range results after a single step are left as-is
  always_comb begin
    acc_next = t;
    if (!bypass) begin
      if (t[DATA_W-1]) begin
        acc_next = t + qs;
      end else if (t >= qs) begin
        acc_next = t - qs;
      end
    end
  end

endmodule

// File: rtl/mas_seq_acc.sv
// Sequential modular accumulator: accepts N_OPS handshaked operands per run and strobes the
// reduced 4-bit result one cycle after the last transfer.
module mas_seq_acc
  import mas_seq_acc_pkg::*;
#(
  parameter int unsigned N_OPS = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] Q,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [OP_W-1:0]   in_op,
  output logic              busy,
  output logic              out_valid,
  output logic [3:0]        out_data,
  output logic              err,
  output logic [CNT_W-1:0]  op_cnt
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(N_OPS - 1);

  state_e            state_q;
  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] q_q;
  logic              err_reg_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              in_ready_q;
  logic              busy_q;
  logic              out_valid_q;
  logic [3:0]        out_data_q;
  logic              err_q;

  logic [DATA_W-1:0] acc_next;
  logic              transfer;

  assign transfer = in_valid && in_ready_q;

  mod_step u_mod_step (
    .acc      (acc_q),
    .d        (in_data),
    .op       (in_op),
    .q        (q_q),
    .bypass   (err_reg_q),
    .acc_next (acc_next)
  );

  // Run-control FSM with registered handshake and result outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      q_q         <= '0;
      err_reg_q   <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      // Result strobe and its error flag are single-cycle
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            q_q        <= Q;
            acc_q      <= '0;
            cnt_q      <= '0;
            err_reg_q  <= is_bad_mod(Q);
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= StRun;
          end
        end
        StRun: begin
          if (transfer) begin
            acc_q <= acc_next;
            if (cnt_q == LastCnt) begin
              // out_data reflects the accumulator as updated on this edge
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              out_data_q  <= acc_next[3:0];
              err_q       <= err_reg_q;
              state_q     <= StDone;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        StDone: begin
          // start during this cycle is deliberately dropped
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= StIdle;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign err       = err_q;
  assign op_cnt    = cnt_q;

endmodule

// File: tb/tb_mas_seq_acc.sv
// Self-checking bench for mas_seq_acc: directed runs from the plan plus randomized runs
// against an integer reference model, on two instances (N_OPS=4 and N_OPS=2).
module tb_mas_seq_acc;

  logic       clk;
  logic       reset;
  logic       start     [2];
  logic [4:0] q_in      [2];
  logic       in_valid  [2];
  logic       in_ready  [2];
  logic [4:0] in_data   [2];
  logic [1:0] in_op     [2];
  logic       busy      [2];
  logic       out_valid [2];
  logic [3:0] out_data  [2];
  logic       err       [2];
  logic [3:0] op_cnt    [2];

  int n_checks = 0;
  int n_fail   = 0;
  int dv [16];
  int ov [16];

  mas_seq_acc #(.N_OPS(4), .CNT_W(4)) u_dut4 (
    .clk       (clk),
    .reset     (reset),
    .start     (start[0]),
    .Q         (q_in[0]),
    .in_valid  (in_valid[0]),
    .in_ready  (in_ready[0]),
    .in_data   (in_data[0]),
    .in_op     (in_op[0]),
    .busy      (busy[0]),
    .out_valid (out_valid[0]),
    .out_data  (out_data[0]),
    .err       (err[0]),
    .op_cnt    (op_cnt[0])
  );

  mas_seq_acc #(.N_OPS(2), .CNT_W(4)) u_dut2 (
    .clk       (clk),
    .reset     (reset),
    .start     (start[1]),
    .Q         (q_in[1]),
    .in_valid  (in_valid[1]),
    .in_ready  (in_ready[1]),
    .in_data   (in_data[1]),
    .in_op     (in_op[1]),
    .busy      (busy[1]),
    .out_valid (out_valid[1]),
    .out_data  (out_data[1]),
    .err       (err[1]),
    .op_cnt    (op_cnt[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Interpret a 5-bit pattern as a signed value
  function automatic int wrap5(input int v);
    int m;
    m = v & 31;
    return (m >= 16) ? m - 32 : m;
  endfunction

  // Reference: plain integer arithmetic, then one modular correction
  function automatic int ref_step(input int acc, input int d, input int op, input int q,
                                  input bit byp);
    int t;
    case (op)
      0:       t = acc + d;
      3:       t = acc - d;
      1:       t = d;
      default: t = acc;
    endcase
    t = wrap5(t);
    if (byp) return t;
    if (t < 0) return wrap5(t + q);
    if (t >= q) return wrap5(t - q);
    return t;
  endfunction

  // One run on instance k. started: start already accepted by caller.
  // poke: pulse start with another Q during the first stall. chain: restart right after DONE.
  task automatic do_run(input int k, input int q, input int stall, input bit rnd_stall,
                        input bit started, input bit poke, input bit chain, input int q_next,
                        output int res);
    int  n;
    int  acc;
    int  qs;
    int  s;
    int  qv;
    bit  byp;
    n   = (k == 0) ? 4 : 2;
    qs  = wrap5(q);
    byp = (qs <= 0);
    acc = 0;
    qv  = q;
    if (!started) begin
      check_eq("idle_busy", busy[k], 0);
      start[k] = 1'b1;
      q_in[k]  = qv[4:0];
      tick();
      start[k] = 1'b0;
    end
    check_eq("run_busy", busy[k], 1);
    check_eq("run_ready", in_ready[k], 1);
    check_eq("cnt_start", op_cnt[k], 0);
    for (int i = 0; i < n; i++) begin
      s = rnd_stall ? int'($urandom_range(0, 2)) : stall;
      if (i > 0) begin
        for (int j = 0; j < s; j++) begin
          in_valid[k] = 1'b0;
          in_data[k]  = 5'($urandom);
          if (poke && j == 0) begin
            qv       = q ^ 3;
            start[k] = 1'b1;
            q_in[k]  = qv[4:0];
          end
          tick();
          start[k] = 1'b0;
          check_eq("stall_cnt", op_cnt[k], i);
          check_eq("stall_ov", out_valid[k], 0);
        end
      end
      in_valid[k] = 1'b1;
      in_data[k]  = 5'(dv[i]);
      in_op[k]    = 2'(ov[i]);
      tick();
      in_valid[k] = 1'b0;
      acc = ref_step(acc, wrap5(dv[i]), ov[i], qs, byp);
      if (i < n - 1) begin
        check_eq("xfer_cnt", op_cnt[k], i + 1);
        check_eq("xfer_ov", out_valid[k], 0);
      end else begin
        check_eq("done_ov", out_valid[k], 1);
        check_eq("done_data", out_data[k], acc & 15);
        check_eq("done_err", err[k], int'(byp));
        check_eq("done_busy", busy[k], 1);
        check_eq("done_ready", in_ready[k], 0);
      end
    end
    res = acc & 15;
    if (chain) begin
      qv       = q_next;
      start[k] = 1'b1;
      q_in[k]  = qv[4:0];
      tick();
      check_eq("done_start_ignored", busy[k], 0);
      check_eq("post_ov", out_valid[k], 0);
      check_eq("post_data_hold", out_data[k], res);
      tick();
      start[k] = 1'b0;
      check_eq("b2b_start_busy", busy[k], 1);
    end else begin
      tick();
      check_eq("post_ov", out_valid[k], 0);
      check_eq("post_err", err[k], 0);
      check_eq("post_busy", busy[k], 0);
      check_eq("post_data_hold", out_data[k], res);
    end
  endtask

  task automatic set_ops(input int d0, input int o0, input int d1, input int o1,
                         input int d2, input int o2, input int d3, input int o3);
    dv[0] = d0; ov[0] = o0;
    dv[1] = d1; ov[1] = o1;
    dv[2] = d2; ov[2] = o2;
    dv[3] = d3; ov[3] = o3;
  endtask

  initial begin
    int res;
    for (int k = 0; k < 2; k++) begin
      start[k] = 1'b0; q_in[k] = '0; in_valid[k] = 1'b0; in_data[k] = '0; in_op[k] = '0;
    end
    reset = 1'b1;
    #12;
    check_eq("rst_busy", busy[0], 0);
    check_eq("rst_ready", in_ready[0], 0);
    check_eq("rst_ov", out_valid[0], 0);
    check_eq("rst_data", out_data[0], 0);
    check_eq("rst_err", err[0], 0);
    check_eq("rst_cnt", op_cnt[0], 0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Q=7: load 5, add 4, sub 6, hold, continuous
    set_ops(5, 1, 4, 0, 6, 3, 0, 2);
    do_run(0, 7, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, res);
    check_eq("plan_cont", res, 3);

    // Same run, 3-cycle stalls, with a mid-run start carrying a different Q
    do_run(0, 7, 3, 1'b0, 1'b0, 1'b1, 1'b0, 0, res);
    check_eq("plan_stall", res, 3);

    // Wrap case on N_OPS=2: load 14, add 15 with Q=15
    set_ops(14, 1, 15, 0, 0, 2, 0, 2);
    do_run(1, 15, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, res);
    check_eq("plan_wrap", res, 12);

    // Q=0: reduction bypassed, err raised
    set_ops(5, 1, 4, 0, 0, 2, 0, 2);
    do_run(1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, res);
    check_eq("plan_bypass", res, 9);

    // Reset after two of four operands
    set_ops(3, 0, 3, 0, 3, 0, 3, 0);
    start[0] = 1'b1; q_in[0] = 5'd7;
    tick();
    start[0] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid[0] = 1'b1; in_data[0] = 5'd3; in_op[0] = 2'b00;
      tick();
    end
    in_valid[0] = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_eq("midrst_busy", busy[0], 0);
    check_eq("midrst_ready", in_ready[0], 0);
    check_eq("midrst_cnt", op_cnt[0], 0);
    check_eq("midrst_ov", out_valid[0], 0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    check_eq("midrst_no_ov", out_valid[0], 0);
    do_run(0, 5, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, res);
    check_eq("plan_after_rst", res, 2);

    // Start during DONE is dropped; start on the following cycle is taken
    set_ops(5, 1, 4, 0, 6, 3, 0, 2);
    do_run(0, 7, 0, 1'b0, 1'b0, 1'b0, 1'b1, 5, res);
    set_ops(3, 0, 3, 0, 3, 0, 3, 0);
    do_run(0, 5, 0, 1'b0, 1'b1, 1'b0, 1'b0, 0, res);
    check_eq("plan_b2b", res, 2);

    // Randomized runs on both instances, including non-positive Q
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < 4; i++) begin
        dv[i] = int'($urandom_range(0, 31));
        ov[i] = int'($urandom_range(0, 3));
      end
      do_run(r % 2, int'($urandom_range(0, 31)), 0, 1'b1, 1'b0, ($urandom_range(0, 3) == 0),
             1'b0, 0, res);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
